// File: rtl/controlador_llamadas.sv
// controlador_llamadas: floor-call dispatcher for the elevator (maquina_estados).
// Latches call buttons and issues one-floor sube/baja requests, scanning in a
// kept direction. Opens the door on arrival and flags a sticky fault when the
// cabin does not report a new floor in time.
//
//   state  | meaning
//   REPOSO | idle / choose next action from pending calls
//   MOVER  | sube or baja pulse is high this cycle
//   ESPERA | waiting for piso to change after the pulse
//   PUERTA | door open, counting down the door timer
module controlador_llamadas #(
    parameter int N_PISOS  = 4,
    parameter int T_PUERTA = 8,
    parameter int T_ESPERA = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_PISOS-1:0] llamada,
    input  logic [1:0]         piso,
    output logic               sube,
    output logic               baja,
    output logic [N_PISOS-1:0] pendientes,
    output logic               puerta,
    output logic               fallo
);

    localparam int T_MAX = (T_PUERTA > T_ESPERA) ? T_PUERTA : T_ESPERA;
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        MOVER  = 2'd1,
        ESPERA = 2'd2,
        PUERTA = 2'd3
    } estado_t;

    estado_t           estado;
    logic              dir;          // 1 = up, 0 = down
    logic [1:0]        piso_prev;
    logic [TW-1:0]     timer;

    logic              arriba;
    logic              abajo;
    logic              pend_piso;
    logic              llam_piso;
    logic              dir_sig;
    logic [N_PISOS-1:0] llamada_ok;
    logic [N_PISOS-1:0] borrar;

    // Call position relative to the cabin and the SCAN direction choice.
    always_comb begin
        arriba = 1'b0;
        abajo  = 1'b0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (i > int'(piso)) arriba = arriba | pendientes[i];
            if (i < int'(piso)) abajo  = abajo  | pendientes[i];
        end
        pend_piso = pendientes[piso];
        llam_piso = llamada[piso];
        dir_sig   = arriba & (dir | ~abajo);
    end

    // Calls to latch (the open-door floor only retriggers the door) and calls served this edge.
    always_comb begin
        llamada_ok = llamada;
        borrar     = '0;
        if (estado == PUERTA) llamada_ok[piso] = 1'b0;
        if (en) begin
            case (estado)
                REPOSO:  if (pend_piso) borrar[piso] = 1'b1;
                ESPERA:  if ((piso != piso_prev) && pend_piso) borrar[piso] = 1'b1;
                default: borrar = '0;
            endcase
        end
    end

    // Dispatcher FSM with registered outputs and shared down-counter timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado     <= REPOSO;
            dir        <= 1'b1;
            piso_prev  <= '0;
            timer      <= '0;
            sube       <= 1'b0;
            baja       <= 1'b0;
            puerta     <= 1'b0;
            fallo      <= 1'b0;
            pendientes <= '0;
        end else begin
            pendientes <= (pendientes | llamada_ok) & ~borrar;
            sube       <= 1'b0;
            baja       <= 1'b0;
            if (en) begin
                case (estado)
                    REPOSO: begin
                        if (pendientes != '0) begin
                            if (pend_piso) begin
                                puerta <= 1'b1;
                                timer  <= TW'(T_PUERTA);
                                estado <= PUERTA;
                            end else begin
                                // piso_prev holds the floor the pulse is issued from,
                                // so an immediate cabin response is not missed.
                                dir       <= dir_sig;
                                sube      <= dir_sig;
                                baja      <= ~dir_sig;
                                piso_prev <= piso;
                                estado    <= MOVER;
                            end
                        end
                    end
                    MOVER: begin
                        timer  <= TW'(T_ESPERA);
                        estado <= ESPERA;
                    end
                    ESPERA: begin
                        if (piso != piso_prev) begin
                            if (pend_piso) begin
                                puerta <= 1'b1;
                                timer  <= TW'(T_PUERTA);
                                estado <= PUERTA;
                            end else begin
                                estado <= REPOSO;
                            end
                        end else if (timer <= TW'(1)) begin
                            fallo  <= 1'b1;
                            estado <= REPOSO;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    PUERTA: begin
                        if (llam_piso) begin
                            timer <= TW'(T_PUERTA);
                        end else if (timer <= TW'(1)) begin
                            puerta <= 1'b0;
                            estado <= REPOSO;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    default: estado <= REPOSO;
                endcase
            end
        end
    end

endmodule
